seg7_mux_driver: RTL and testbench

Time-multiplexed driver for a parametrised bank of common-cathode seven-segment digits. Takes a packed BCD/hex value, holds it in a double-buffered display register, and scans one digit at a time with an anti-ghosting blank slot, optional leading-zero blanking and per-digit decimal points. Sits between the counter/datapath logic and the output pins of the tile.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/seg7_decode.sv | 18 +
 rtl/seg7_mux_driver.sv | 128 ++++++++++++
 tb/tb_seg7_mux_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and the nibble-to-glyph lookup shared by the
// scan driver and its decoder. Bit order: 6=middle .. 0=top.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  // Nibbles 10..15 fall back to blank when hex display is disabled.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble, input logic hex_en);
    logic [6:0] g;
    case (nibble)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = hex_en ? SEG_A : SEG_BLANK;
      4'hB: g = hex_en ? SEG_B : SEG_BLANK;
      4'hC: g = hex_en ? SEG_C : SEG_BLANK;
      4'hD: g = hex_en ? SEG_D : SEG_BLANK;
      4'hE: g = hex_en ? SEG_E : SEG_BLANK;
      default: g = hex_en ? SEG_F : SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder for the currently scanned digit.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int HEX_EN = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  localparam logic HEX = (HEX_EN != 0);

  // Pure lookup; no state.
  always_comb begin
    glyph = seg7_glyph(nibble, HEX);
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed common-cathode seven-segment driver: prescaled digit scan,
// double-buffered display value, blank slot between digits, leading-zero
// blanking and per-digit decimal points. All outputs are registered.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int HEX_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     pend_val_q, pend_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [VW-1:0]     act_val_q, act_val_d;
  logic [DIGITS-1:0] act_dp_q, act_dp_d;
  logic [6:0]        segments_q, segments_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic              frame_done_q, frame_done_d;

  logic              pre_wrap, frame_wrap;
  logic [3:0]        sel_nib;
  logic              sel_dp;
  logic              lz_blank;
  logic              nz_seen;
  logic [DIGITS-1:0] en_onehot;
  logic              slot_blank;
  logic [6:0]        glyph;

  seg7_decode #(.HEX_EN(HEX_EN)) u_decode (
    .nibble (sel_nib),
    .glyph  (glyph)
  );

  // Scan counters and double buffer; active only swaps at the frame boundary
  // so a frame is never torn, and a load on that very cycle goes straight in.
  always_comb begin
    pre_wrap   = (pre_q == PRE_LAST);
    frame_wrap = pre_wrap && (idx_q == IDX_LAST);
    pre_d      = pre_wrap ? '0 : pre_q + PW'(1);
    idx_d      = idx_q;
    if (pre_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    act_val_d  = frame_wrap ? pend_val_d : act_val_q;
    act_dp_d   = frame_wrap ? pend_dp_d  : act_dp_q;
  end

  // Select the scanned digit; walk from the top digit down so nz_seen tells
  // whether any digit at or above k is non-zero (leading-zero test).
  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    lz_blank  = 1'b0;
    nz_seen   = 1'b0;
    en_onehot = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_seen = nz_seen | (act_val_q[4*k +: 4] != 4'h0);
      en_onehot[k] = (idx_q == IW'(k));
      if (idx_q == IW'(k)) begin
        sel_nib  = act_val_q[4*k +: 4];
        sel_dp   = act_dp_q[k];
        lz_blank = blank_lz && !nz_seen && (k != 0);
      end
    end
  end

  // Output stage: the first cycle of every slot is dark to avoid ghosting.
  always_comb begin
    slot_blank   = (pre_q == '0);
    digit_en_d   = slot_blank ? '0 : en_onehot;
    segments_d   = (slot_blank || lz_blank) ? SEG_BLANK : glyph;
    dp_d         = !slot_blank && sel_dp;
    frame_done_d = frame_wrap;
  end

  // State and output registers; reset discards any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      segments_q   <= '0;
      dp_q         <= 1'b0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments   = segments_q;
  assign dp         = dp_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver: two instances (hex on / hex off) share
// stimulus; expected lit-slot glyphs are queued per frame and a monitor pops
// them at each slot start, while a cycle-count model checks scan timing.
module tb_seg7_mux_driver;

  localparam int D  = 4;
  localparam int R  = 4;
  localparam int FR = D * R;

  localparam logic [6:0] B  = 7'b0000000;
  localparam logic [6:0] G0 = 7'b0111111;
  localparam logic [6:0] G1 = 7'b0000110;
  localparam logic [6:0] G2 = 7'b1011011;
  localparam logic [6:0] G3 = 7'b1001111;
  localparam logic [6:0] G4 = 7'b1100110;
  localparam logic [6:0] G5 = 7'b1101101;
  localparam logic [6:0] G6 = 7'b1111101;
  localparam logic [6:0] G7 = 7'b0000111;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] G9 = 7'b1101111;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] Gb = 7'b1111100;
  localparam logic [6:0] GC = 7'b0111001;
  localparam logic [6:0] GF = 7'b1110001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          blank_lz = 1'b1;
  logic [15:0]   value = '0;
  logic [D-1:0]  dp_in = '0;

  logic [6:0]    seg1, seg0;
  logic          dp1, dp0;
  logic [D-1:0]  en1, en0;
  logic          fd1, fd0;

  seg7_mux_driver #(.DIGITS(D), .REFRESH_DIV(R), .HEX_EN(1)) u_h1 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
    .blank_lz(blank_lz), .segments(seg1), .dp(dp1), .digit_en(en1), .frame_done(fd1)
  );

  seg7_mux_driver #(.DIGITS(D), .REFRESH_DIV(R), .HEX_EN(0)) u_h0 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
    .blank_lz(blank_lz), .segments(seg0), .dp(dp0), .digit_en(en0), .frame_done(fd0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] en;
    logic [6:0]   s1;
    logic [6:0]   s0;
    logic         dp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endfunction

  // Queue the lit slots of one frame; packed args are {d3,d2,d1,d0}.
  task automatic push_frame(input logic [27:0] h1, input logic [27:0] h0,
                            input logic [3:0] dpv, input int nd);
    exp_t e;
    for (int k = 0; k < nd; k++) begin
      e.en = 4'(1 << k);
      e.s1 = h1[7*k +: 7];
      e.s0 = h0[7*k +: 7];
      e.dp = dpv[k];
      q.push_back(e);
    end
  endtask

  // Monitor: cycle model for scan/frame_done, blank-cycle and glyph checks.
  logic         rst_smp = 1'b1;
  int           cyc = -1;
  int           mp, mslot, min;
  logic [D-1:0] een;
  logic         efd;
  logic [D-1:0] prev_en = '0;
  exp_t         cur;
  logic         cur_vld = 1'b0;

  always @(posedge clk) rst_smp = rst;

  always @(negedge clk) begin
    if (rst_smp) begin
      cyc = 0;
      cur_vld = 1'b0;
    end else begin
      cyc++;
    end
    if (cyc == 0) begin
      een = '0;
      efd = 1'b0;
    end else begin
      mp    = cyc - 1;
      min   = mp % R;
      mslot = (mp / R) % D;
      een   = (min == 0) ? '0 : 4'(1 << mslot);
      efd   = (cyc % FR) == 0;
    end
    check("scan", {22'd0, en1, en0, fd1, fd0}, {22'd0, een, een, efd, efd});
    if (en1 == '0) begin
      check("blank", {16'd0, seg1, seg0, dp1, dp0}, 32'd0);
    end else begin
      if (prev_en == '0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          cur_vld = 1'b0;
          $display("FAIL slot_unexpected actual=en %b required=no lit slot t=%0t", en1, $time);
        end else begin
          cur = q.pop_front();
          cur_vld = 1'b1;
        end
      end
      if (cur_vld)
        check("glyph", {8'd0, en1, en0, seg1, seg0, dp1, dp0},
              {8'd0, cur.en, cur.en, cur.s1, cur.s0, cur.dp, cur.dp});
    end
    prev_en = en1;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fd;
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (fd1 !== 1'b1 && n < 100);
    if (fd1 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_done actual=timeout required=pulse within 100 cycles");
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    // cycle 0: release reset and load 1234 into pending
    rst   = 1'b0;
    load  = 1'b1;
    value = 16'h1234;
    dp_in = 4'b0000;
    push_frame({B, B, B, G0}, {B, B, B, G0}, 4'b0000, 4);
    push_frame({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b0000, 4);
    tick();
    load = 1'b0;

    wait_fd();                                   // end of frame 0
    do_load(16'h0070, 4'b0000);
    wait_fd();                                   // end of frame 1
    push_frame({B, B, G7, G0}, {B, B, G7, G0}, 4'b0000, 4);
    do_load(16'h0000, 4'b0000);
    wait_fd();
    push_frame({B, B, B, G0}, {B, B, B, G0}, 4'b0000, 4);
    do_load(16'hFA0B, 4'b0000);
    wait_fd();
    push_frame({GF, GA, G0, Gb}, {B, B, G0, B}, 4'b0000, 4);
    do_load(16'h0070, 4'b0100);
    wait_fd();
    push_frame({B, B, G7, G0}, {B, B, G7, G0}, 4'b0100, 4);
    wait_fd();
    blank_lz = 1'b0;
    push_frame({G0, G0, G7, G0}, {G0, G0, G7, G0}, 4'b0100, 4);
    wait_fd();
    blank_lz = 1'b1;
    push_frame({B, B, G7, G0}, {B, B, G7, G0}, 4'b0100, 4);
    repeat (9) tick();                           // scan is on digit 2
    do_load(16'h5678, 4'b0000);
    wait_fd();
    push_frame({G5, G6, G7, G8}, {G5, G6, G7, G8}, 4'b0000, 4);
    repeat (15) tick();                          // wrap cycle of this frame
    load  = 1'b1;
    value = 16'h9ABC;
    dp_in = 4'b0000;
    push_frame({G9, GA, Gb, GC}, {G9, B, B, B}, 4'b0000, 4);
    tick();
    load = 1'b0;
    wait_fd();
    push_frame({G9, GA, Gb, GC}, {G9, B, B, B}, 4'b0000, 3);
    do_load(16'h1111, 4'b1111);                  // pending only, must be discarded
    repeat (9) tick();                           // digit 2 lit now
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_frame({B, B, B, G0}, {B, B, B, G0}, 4'b0000, 4);
    push_frame({B, B, B, G0}, {B, B, B, G0}, 4'b0000, 4);
    wait_fd();
    wait_fd();
    check("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
